ysyx_22040632_ifu_fetch: RTL

//  Instruction fetch stage feeding the decode stage. Owns the architectural PC, issues one
//  32-bit fetch at a time on a valid/ready memory request channel, and holds the returned

---
 rtl/ysyx_22040632_ifu_fetch.sv | 101 ++++++++++
 1 files changed

// File: rtl/ysyx_22040632_ifu_fetch.sv
// ysyx_22040632_ifu_fetch: single-outstanding instruction fetch with redirect, stale-response drop and sticky fault
module ysyx_22040632_ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_data,
    input  logic             mem_rsp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_count
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
    state_t            r_state, w_state;
    logic [XLEN-1:0]   r_pc_q, w_pc_q, r_pc, w_pc, r_pend, w_pend;
    logic [31:0]       r_inst, w_inst;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_drop, w_drop, w_redir;
    always_comb begin
        w_state = r_state;
        w_pc_q  = r_pc_q;
        w_pc    = r_pc;
        w_pend  = r_pend;
        w_inst  = r_inst;
        w_cnt   = r_cnt;
        w_drop  = r_drop;
        w_redir = redirect_valid && r_state != S_FAULT;
        case (r_state)
            S_IDLE: begin
                w_state = S_REQ;
                w_pc_q  = w_redir ? redirect_pc : r_pc_q;
            end
            S_REQ: begin
                w_state = mem_req_ready ? S_WAIT : S_REQ;
                w_drop  = r_drop | w_redir;
                w_pend  = w_redir ? redirect_pc : r_pend;
            end
            S_WAIT: begin
                // A redirect arriving with the response makes that response stale too
                if (mem_rsp_valid && (r_drop || w_redir)) begin
                    w_state = S_REQ;
                    w_pc_q  = w_redir ? redirect_pc : r_pend;
                    w_drop  = 1'b0;
                end else if (mem_rsp_valid && mem_rsp_err) begin
                    w_state = S_FAULT;
                end else if (mem_rsp_valid) begin
                    w_state = S_HOLD;
                    w_inst  = mem_rsp_data;
                    w_pc    = r_pc_q;
                end else begin
                    w_drop  = r_drop | w_redir;
                    w_pend  = w_redir ? redirect_pc : r_pend;
                end
            end
            S_HOLD: begin
                w_cnt   = inst_ready ? r_cnt + CNT_W'(1) : r_cnt;
                w_state = (w_redir || inst_ready) ? S_REQ : S_HOLD;
                w_pc_q  = w_redir ? redirect_pc : inst_ready ? r_pc_q + XLEN'(4) : r_pc_q;
            end
            default: w_state = S_FAULT;
        endcase
        if (w_redir && redirect_pc[1:0] != 2'b00) w_state = S_FAULT;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc_q  <= RESET_PC;
            r_pc    <= RESET_PC;
            r_pend  <= RESET_PC;
            r_inst  <= '0;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pc_q  <= w_pc_q;
            r_pc    <= w_pc;
            r_pend  <= w_pend;
            r_inst  <= w_inst;
            r_cnt   <= w_cnt;
            r_drop  <= w_drop;
        end
    end
    assign mem_req_valid = r_state == S_REQ;
    assign mem_req_addr  = r_pc_q;
    assign inst_valid    = r_state == S_HOLD;
    assign inst          = r_inst;
    assign pc            = r_pc;
    assign fetch_fault   = r_state == S_FAULT;
    assign fetch_count   = r_cnt;
endmodule
